// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
//
// Assembles 11-bit PS/2 device-to-host frames from the debounced clock and
// data lines. A frame is a start bit (0), eight data bits sent LSB first, an
// odd parity bit and a stop bit (1). Each good byte goes into a hold register
// that the consumer drains with a valid/ack handshake. Parity, framing,
// timeout and overrun conditions are reported as single-cycle pulses.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles allowed between falling edges of ps2_clk_db
//                   mid-frame before the partial frame is abandoned
//   TO_W            width of the timeout counter (derived)
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   ps2_clk_db     debounced PS/2 clock line
//   ps2_data_db    debounced PS/2 data line
//   rx_ack         consumer has taken rx_data (only meaningful while rx_valid)
//   rx_data        last good byte, stable while rx_valid is high
//   rx_valid       a byte is waiting in the hold register
//   rx_parity_err  pulse: frame had bad parity
//   rx_frame_err   pulse: stop bit was 0
//   rx_timeout     pulse: frame abandoned because the PS/2 clock stalled
//   rx_overrun     pulse: good byte dropped because the hold register was full
//   busy           high while a frame is being received
// ---------------------------------------------------------------------------
module ps2_rx_frame #(
  parameter  int TIMEOUT_CYCLES = 5000,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_db,
  input  logic       ps2_data_db,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_timeout,
  output logic       rx_overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  state_t          state;
  logic            clk_prev;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            fall;

  // A falling edge of the PS/2 clock is the moment the device guarantees the
  // data line is valid, so data is only ever sampled in a fall cycle.
  assign fall = clk_prev & ~ps2_clk_db;

  // Frame receiver, hold register and error pulses in one registered process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      clk_prev      <= 1'b1;
      shift         <= 8'h00;
      bit_cnt       <= 3'd0;
      par_bit       <= 1'b0;
      to_cnt        <= '0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_timeout    <= 1'b0;
      rx_overrun    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      clk_prev      <= ps2_clk_db;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_timeout    <= 1'b0;
      rx_overrun    <= 1'b0;

      // Consumer acknowledge; a byte loaded at a stop edge below overrides
      // this clear, which is how ack and a new byte in the same cycle keep
      // rx_valid high.
      if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end

      if (state == IDLE) begin
        to_cnt <= '0;
        // A fall with data high is a line glitch, not a start bit.
        if (fall && !ps2_data_db) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
          busy    <= 1'b1;
        end
      end else if (fall) begin
        // A fall always beats the timeout, even on the last allowed cycle.
        to_cnt <= '0;
        if (state == DATA) begin
          shift   <= {ps2_data_db, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= PARITY;
          end
        end else if (state == PARITY) begin
          par_bit <= ps2_data_db;
          state   <= STOP;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          // Parity is checked before the stop bit so a frame reports at most
          // one error.
          if (!(^{shift, par_bit})) begin
            rx_parity_err <= 1'b1;
          end else if (!ps2_data_db) begin
            rx_frame_err <= 1'b1;
          end else if (!rx_valid || rx_ack) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
        end
      end else if (to_cnt == TO_LAST) begin
        state      <= IDLE;
        busy       <= 1'b0;
        rx_timeout <= 1'b1;
        to_cnt     <= '0;
      end else if (to_cnt < TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Downstream of the PS/2 line debouncers. Consumes the debounced PS/2 clock and data lines and assembles 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop. Presents each received byte to the scan-code/68k interface logic through a valid/ack hold register. Flags parity, framing, timeout and overrun conditions.

Parameters:
TIMEOUT_CYCLES, 5000, clk cycles allowed between consecutive falling edges of ps2_clk_db mid-frame before the frame is aborted.
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter; derived, never overridden.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
ps2_clk_db  input  1  debounced PS/2 clock line.
ps2_data_db  input  1  debounced PS/2 data line.
rx_ack  input  1  consumer has taken rx_data; sampled only while rx_valid=1.
rx_data  output  8  last good byte; stable while rx_valid=1.
rx_valid  output  1  level; byte available.
rx_parity_err  output  1  1-cycle pulse on bad parity.
rx_frame_err  output  1  1-cycle pulse on stop bit = 0.
rx_timeout  output  1  1-cycle pulse on mid-frame timeout.
rx_overrun  output  1  1-cycle pulse when a good byte is dropped.
busy  output  1  high while state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, clk_prev=1, shift=0, bit count=0, timeout counter=0, rx_data=0x00, rx_valid=0, all pulse outputs=0, busy=0. Reset mid-frame discards the partial frame with no error pulse.
- Edge detect: clk_prev is registered from ps2_clk_db. fall = clk_prev & ~ps2_clk_db. ps2_data_db is sampled in the same cycle fall=1. No other input synchronisation is performed here.
- States:
  - IDLE: on fall with data=0 -> DATA, bit count=0. On fall with data=1 -> stay IDLE, no error pulse.
  - DATA: on each fall, shift data in at bit[7] and shift right (LSB first). After the 8th bit -> PARITY.
  - PARITY: on fall, capture the parity bit -> STOP.
  - STOP: on fall, evaluate the frame, then -> IDLE.
- Evaluation order at the stop edge:
  - Parity is odd-good: XOR of 8 data bits and parity bit must be 1. If bad, pulse rx_parity_err and discard.
  - Otherwise, if stop=0, pulse rx_frame_err and discard.
  - Otherwise the byte is good.
- Latency: if fall occurs in cycle N on the stop bit, outputs change at the posedge ending N. rx_valid/rx_data or the error pulse are visible in cycle N+1.
- Hold register and handshake:
  - Good byte with rx_valid=0: load rx_data, set rx_valid.
  - rx_ack=1 while rx_valid=1: clear rx_valid next cycle. rx_ack with rx_valid=0 is ignored.
  - Good byte with rx_valid=1 and rx_ack=1 in the same cycle: load new byte, rx_valid stays 1.
  - Good byte with rx_valid=1 and rx_ack=0: keep old rx_data, drop new byte, pulse rx_overrun.
- Timeout:
  - The counter clears on every fall and in IDLE, and increments each cycle otherwise (in DATA/PARITY/STOP).
  - When the counter reaches TIMEOUT_CYCLES-1 with no fall: -> IDLE, pulse rx_timeout, counter=0.
  - A fall in the same cycle wins over timeout.
  - The counter saturates and never wraps.
- busy=1 in DATA, PARITY and STOP.
- Pulse outputs are registered, exactly one cycle wide, and mutually exclusive per frame.

Test Plan:
1. Good frame: send 0x1C (bits 0,0,1,1,1,0,0,0), parity 0, stop 1; bit period 40 clk -> rx_valid=1, rx_data=0x1C one cycle after the 11th fall. No error pulses; rx_valid holds until rx_ack is pulsed, then drops next cycle.
2. Back-to-back with ack: 0xF0 (parity 1) then 0x1C; consumer acks each within 5 cycles -> two rx_valid assertions, data 0xF0 then 0x1C, rx_overrun never set.
3. Errors:
   - 0x1C sent with parity=1 -> single rx_parity_err pulse, rx_valid stays 0.
   - 0x1C with correct parity and stop=0 -> single rx_frame_err pulse, rx_valid stays 0.
4. Overrun: 0x1C with no ack, then 0xF0 -> rx_overrun pulse at the 0xF0 stop edge, rx_data stays 0x1C. Repeat with rx_ack=1 held on the 0xF0 stop cycle -> rx_data=0xF0, no overrun.
5. Timeout: TIMEOUT_CYCLES=64; send start plus 4 data bits, then hold ps2_clk_db high -> rx_timeout pulses 64 cycles after the last fall, busy drops. A following full 0x1C frame is received correctly.
6. Glitch and reset:
   - Fall with data=1 in IDLE -> ignored, busy stays 0.
   - Assert reset after 6 data bits -> state IDLE, rx_valid=0, no pulses; next 0xF0 frame is received correctly.
